// File: rtl/ibex_ex_block_iter.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier / restoring divider.
// Optional macro IBEX_EX_EARLY_TERM_EN ends MUL/MULH early once the remaining multiplier bits are zero.
module ibex_ex_block_iter #(
  parameter int unsigned WIDTH           = 32,
  parameter bit          RV32M           = 1'b1,
  parameter bit          BranchTargetALU = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       alu_operator_i,
  input  logic [WIDTH-1:0] alu_operand_a_i,
  input  logic [WIDTH-1:0] alu_operand_b_i,
  input  logic [WIDTH-1:0] bt_a_operand_i,
  input  logic [WIDTH-1:0] bt_b_operand_i,
  input  logic             multdiv_en_i,
  input  logic [1:0]       multdiv_operator_i,
  input  logic [1:0]       multdiv_signed_mode_i,
  input  logic [WIDTH-1:0] multdiv_operand_a_i,
  input  logic [WIDTH-1:0] multdiv_operand_b_i,
  input  logic             multdiv_ready_id_i,
  input  logic             data_ind_timing_i,
  output logic [WIDTH-1:0] alu_adder_result_ex_o,
  output logic [WIDTH-1:0] branch_target_o,
  output logic             branch_decision_o,
  output logic [WIDTH-1:0] result_ex_o,
  output logic             ex_valid_o,
  output logic             busy_o
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned DW  = 2 * WIDTH;

  logic [WIDTH-1:0] adder;
  logic [WIDTH-1:0] alu_result;
  logic             cmp;

  // ALU; compare ops return the flag zero-extended
  always_comb begin
    adder      = (alu_operator_i == 3'd1) ? (alu_operand_a_i - alu_operand_b_i)
                                          : (alu_operand_a_i + alu_operand_b_i);
    cmp        = 1'b0;
    alu_result = adder;
    case (alu_operator_i)
      3'd2:    alu_result = alu_operand_a_i ^ alu_operand_b_i;
      3'd3:    alu_result = alu_operand_a_i | alu_operand_b_i;
      3'd4:    alu_result = alu_operand_a_i & alu_operand_b_i;
      3'd5:    cmp = $signed(alu_operand_a_i) < $signed(alu_operand_b_i);
      3'd6:    cmp = alu_operand_a_i < alu_operand_b_i;
      3'd7:    cmp = alu_operand_a_i == alu_operand_b_i;
      default: ;
    endcase
    if (alu_operator_i >= 3'd5) alu_result = WIDTH'(cmp);
  end

  assign alu_adder_result_ex_o = adder;
  assign branch_decision_o     = cmp;

  if (BranchTargetALU) begin : g_bt
    assign branch_target_o = bt_a_operand_i + bt_b_operand_i;
  end else begin : g_bt_alu
    logic unused_bt;
    assign branch_target_o = adder;
    assign unused_bt       = ^{bt_a_operand_i, bt_b_operand_i};
  end

  if (RV32M) begin : g_md
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

    md_state_e        state_q, state_d;
    logic [1:0]       op_q;
    logic             neg_a_q, neg_b_q, ovf_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_mag_q, b_mag_q, rem_q, quo_q, result_q;
    logic [DW-1:0]    acc_q;

    logic             neg_a, neg_b, ovf, last_step, early_term, rem_ge;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix, a_val, fix_result;
    logic [WIDTH:0]   rem_shift, rem_sub;
    logic [DW-1:0]    acc_add, prod;

    // Operand capture: magnitudes plus the one overflow case of signed division
    always_comb begin
      neg_a = multdiv_signed_mode_i[0] & multdiv_operand_a_i[WIDTH-1];
      neg_b = multdiv_signed_mode_i[1] & multdiv_operand_b_i[WIDTH-1];
      a_mag = neg_a ? -multdiv_operand_a_i : multdiv_operand_a_i;
      b_mag = neg_b ? -multdiv_operand_b_i : multdiv_operand_b_i;
      ovf   = multdiv_operator_i[1] & (&multdiv_signed_mode_i) &
              (multdiv_operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&multdiv_operand_b_i);
    end

    // One iteration: dividend bits shift out of quo_q into the remainder
    always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      rem_sub   = rem_shift - {1'b0, b_mag_q};
      rem_ge    = rem_shift >= {1'b0, b_mag_q};
      acc_add   = acc_q + (DW'(a_mag_q) << count_q);
      last_step = count_q == CW'(WIDTH - 1);
    end

`ifdef IBEX_EX_EARLY_TERM_EN
    assign early_term = !op_q[1] && !data_ind_timing_i &&
                        ((b_mag_q >> (CW1'(count_q) + CW1'(1))) == '0);
`else
    logic unused_dit;
    assign early_term = 1'b0;
    assign unused_dit = data_ind_timing_i;
`endif

    // Sign correction and special-case override
    always_comb begin
      prod    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
      rem_fix = neg_a_q ? -rem_q : rem_q;
      a_val   = neg_a_q ? -a_mag_q : a_mag_q;
      case (op_q)
        2'd0:    fix_result = prod[WIDTH-1:0];
        2'd1:    fix_result = prod[DW-1:WIDTH];
        2'd2:    fix_result = (b_mag_q == '0) ? '1 :
                              ovf_q ? {1'b1, {(WIDTH-1){1'b0}}} : quo_fix;
        default: fix_result = (b_mag_q == '0) ? a_val : ovf_q ? '0 : rem_fix;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
    end

    always_comb begin
      state_d     = state_q;
      busy_o      = state_q != IDLE;
      ex_valid_o  = 1'b0;
      result_ex_o = alu_result;
      case (state_q)
        IDLE: begin
          ex_valid_o = !multdiv_en_i;
          if (multdiv_en_i) state_d = CALC;
        end
        CALC: begin
          if (!multdiv_en_i)                state_d = IDLE;
          else if (last_step || early_term) state_d = FIX;
        end
        FIX:  state_d = multdiv_en_i ? DONE : IDLE;
        DONE: begin
          ex_valid_o  = 1'b1;
          result_ex_o = result_q;
          if (!multdiv_en_i || multdiv_ready_id_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        op_q     <= '0;
        neg_a_q  <= 1'b0;
        neg_b_q  <= 1'b0;
        ovf_q    <= 1'b0;
        count_q  <= '0;
        a_mag_q  <= '0;
        b_mag_q  <= '0;
        rem_q    <= '0;
        quo_q    <= '0;
        acc_q    <= '0;
        result_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (multdiv_en_i) begin
            op_q    <= multdiv_operator_i;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            ovf_q   <= ovf;
            a_mag_q <= a_mag;
            b_mag_q <= b_mag;
            count_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
          end
          CALC: if (multdiv_en_i) begin
            count_q <= count_q + 1'b1;
            if (op_q[1]) begin
              rem_q <= rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], rem_ge};
            end else if (b_mag_q[count_q]) begin
              acc_q <= acc_add;
            end
          end
          FIX:     result_q <= fix_result;
          default: ;
        endcase
      end
    end
  end else begin : g_no_md
    logic unused_md;
    assign busy_o      = 1'b0;
    assign ex_valid_o  = 1'b1;
    assign result_ex_o = alu_result;
    assign unused_md   = ^{clk_i, rst_ni, multdiv_en_i, multdiv_operator_i, multdiv_signed_mode_i,
                           multdiv_operand_a_i, multdiv_operand_b_i, multdiv_ready_id_i,
                           data_ind_timing_i};
  end

endmodule

// File: tb/tb_ibex_ex_block_iter.sv
// Directed bench for ibex_ex_block_iter (WIDTH=32): ALU ops, mul/div results, latency, backpressure, abort, reset.
module tb_ibex_ex_block_iter;

  localparam int unsigned W    = 32;
  localparam int          FULL = W + 2;
`ifdef IBEX_EX_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk, rst_n;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, bt_a, bt_b;
  logic         md_en;
  logic [1:0]   md_op, md_sm;
  logic [W-1:0] md_a, md_b;
  logic         ready, dit;
  logic [W-1:0] adder, btarget, result;
  logic         bdec, valid, busy;

  int total = 0;
  int bad   = 0;

  ibex_ex_block_iter #(.WIDTH(W), .RV32M(1'b1), .BranchTargetALU(1'b0)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .alu_operator_i        (alu_op),
    .alu_operand_a_i       (alu_a),
    .alu_operand_b_i       (alu_b),
    .bt_a_operand_i        (bt_a),
    .bt_b_operand_i        (bt_b),
    .multdiv_en_i          (md_en),
    .multdiv_operator_i    (md_op),
    .multdiv_signed_mode_i (md_sm),
    .multdiv_operand_a_i   (md_a),
    .multdiv_operand_b_i   (md_b),
    .multdiv_ready_id_i    (ready),
    .data_ind_timing_i     (dit),
    .alu_adder_result_ex_o (adder),
    .branch_target_o       (btarget),
    .branch_decision_o     (bdec),
    .result_ex_o           (result),
    .ex_valid_o            (valid),
    .busy_o                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mul_lat(input int hb);
    return ET ? hb + 3 : FULL;
  endfunction

  // Enter at posedge+1; start op with ready high, locate first valid cycle, then drop en
  task automatic run_md(input string tag, input logic [1:0] op, input logic [1:0] sm,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_res);
    int lat;
    lat   = -1;
    md_op = op;
    md_sm = sm;
    md_a  = a;
    md_b  = b;
    ready = 1'b1;
    md_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_busy_done"}, busy, 1'b1);
    @(posedge clk); #1;
    md_en = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    alu_op = 3'd0;
    alu_a  = '0;
    alu_b  = '0;
    bt_a   = 32'h1000;
    bt_b   = 32'h0004;
    md_en  = 1'b0;
    md_op  = 2'd0;
    md_sm  = 2'd0;
    md_a   = '0;
    md_b   = '0;
    ready  = 1'b1;
    dit    = 1'b0;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    alu_op = 3'd1; alu_a = 32'd5; alu_b = 32'd7;
    @(negedge clk);
    chk("sub_res", result, 32'hFFFF_FFFE);
    chk("sub_adder", adder, 32'hFFFF_FFFE);
    chk("sub_valid", valid, 1'b1);
    chk("sub_bdec", bdec, 1'b0);
    @(posedge clk); #1;

    alu_op = 3'd5; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
    @(negedge clk);
    chk("slt_res", result, 32'd1);
    chk("slt_bdec", bdec, 1'b1);
    chk("slt_valid", valid, 1'b1);
    @(posedge clk); #1;

    alu_op = 3'd6;
    @(negedge clk);
    chk("sltu_res", result, 32'd0);
    chk("sltu_bdec", bdec, 1'b0);
    @(posedge clk); #1;

    alu_op = 3'd0; alu_a = 32'h10; alu_b = 32'h20;
    @(negedge clk);
    chk("add_res", result, 32'h30);
    chk("add_btarget", btarget, 32'h30);
    @(posedge clk); #1;

    alu_op = 3'd2; alu_a = 32'hF0F0; alu_b = 32'hFF00;
    @(negedge clk);
    chk("xor_res", result, 32'h0FF0);
    @(posedge clk); #1;

    alu_op = 3'd7; alu_a = 32'd3; alu_b = 32'd3;
    @(negedge clk);
    chk("eq_res", result, 32'd1);
    chk("eq_bdec", bdec, 1'b1);
    @(posedge clk); #1;

    run_md("mul_7x6",     2'd0, 2'b00, 32'd7,         32'd6,         mul_lat(2), 32'd42);
    run_md("mulh_s",      2'd1, 2'b11, 32'h8000_0000, 32'd2,         mul_lat(1), 32'hFFFF_FFFF);
    run_md("div_s",       2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2,         FULL,       32'hFFFF_FFFD);
    run_md("rem_s",       2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2,         FULL,       32'hFFFF_FFFF);
    run_md("div_by0",     2'd2, 2'b00, 32'd5,         32'd0,         FULL,       32'hFFFF_FFFF);
    run_md("rem_by0",     2'd3, 2'b00, 32'h1234,      32'd0,         FULL,       32'h1234);
    run_md("div_ovf",     2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, FULL,       32'h8000_0000);
    run_md("rem_ovf",     2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, FULL,       32'd0);

    // Backpressure: hold DONE for 5 cycles with ready low
    md_op = 2'd0; md_sm = 2'b00; md_a = 32'd3; md_b = 32'd5; ready = 1'b0; md_en = 1'b1;
    lat = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("bp_lat", 64'(lat), 64'(mul_lat(2)));
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", valid, 1'b1);
      chk("bp_res", result, 32'd15);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("bp_busy_hold", busy, 1'b1);
    ready = 1'b1;
    @(posedge clk); #1;
    md_en = 1'b0;
    @(negedge clk);
    chk("bp_busy_after", busy, 1'b0);
    chk("bp_valid_after", valid, 1'b1);
    @(posedge clk); #1;

    // Abort: drop en in cycle 10
    md_op = 2'd2; md_sm = 2'b00; md_a = 32'd100; md_b = 32'd7; md_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    md_en = 1'b0;
    @(negedge clk);
    chk("abort_busy_c10", busy, 1'b1);
    chk("abort_valid_c10", valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_c11", busy, 1'b0);
    chk("abort_valid_c11", valid, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC
    md_op = 2'd0; md_a = 32'd9; md_b = 32'hFFFF; md_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    md_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_md("div_u",       2'd2, 2'b00, 32'd100,       32'd7,         FULL,       32'd14);
    run_md("rem_u",       2'd3, 2'b00, 32'd100,       32'd7,         FULL,       32'd2);

`ifdef IBEX_EX_EARLY_TERM_EN
    dit = 1'b0;
    run_md("et_mul_3x1",  2'd0, 2'b00, 32'd3,         32'd1,         3,          32'd3);
    dit = 1'b1;
    run_md("dit_mul_3x1", 2'd0, 2'b00, 32'd3,         32'd1,         FULL,       32'd3);
    dit = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
